// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampled UART receiver.
//   Two-flop input synchroniser, three-sample history with majority voting at
//   mid-bit, start-glitch rejection, optional parity, 1 or 2 stop bits, break
//   detection, and a valid/ready output port that holds the word until taken.
// Ports:
//   clk_div    in   oversample clock (OVERSAMPLE cycles per bit), rising edge
//   rst        in   asynchronous active-high reset
//   rx         in   raw serial line, idle high, asynchronous to clk_div
//   rx_data    out  received word, bit0 = first data bit on the line
//   rx_valid   out  rx_data/parity_err/frame_err valid; held until rx_ready
//   rx_ready   in   consumer takes the word when rx_valid & rx_ready
//   parity_err out  parity mismatch for rx_data (always 0 without parity)
//   frame_err  out  a stop bit of the frame in rx_data was sampled 0
//   overrun    out  1-cycle pulse: a frame completed while the old word was unread
//   break_det  out  1-cycle pulse: data, parity and first stop all sampled 0
//   busy       out  receiver FSM is not idle
module uart_rx_core #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 2,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                 clk_div,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             ODD_PAR   = (PARITY_MODE == 1);
  localparam logic             HAS_PAR   = (PARITY_MODE != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE,
    ST_BRK_WAIT
  } state_t;

  // Input synchroniser and sample history (r_s0 newest)
  logic r_sync1, r_sync2;
  logic r_s0, r_s1, r_s2;

  // FSM and frame assembly state
  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr_f;
  logic                 r_ferr_f;
  logic                 r_brk_f;

  // Registered outputs
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_ovr;
  logic                 r_brk;
  logic                 r_busy;

  logic             w_maj;
  logic             w_mid;
  logic             w_fall;
  logic             w_par_bad;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Majority of the three newest samples, evaluated at the bit centre
  assign w_maj     = (r_s0 & r_s1) | (r_s0 & r_s2) | (r_s1 & r_s2);
  assign w_mid     = (r_cnt == CNT_MID);
  assign w_fall    = r_s1 & ~r_s0;
  assign w_par_bad = (((^r_shift) ^ w_maj) != ODD_PAR);
  assign w_cnt_nxt = (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);

  // Synchroniser and history reset to idle-high so reset never fakes a start edge
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_s0    <= 1'b1;
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_s0    <= r_sync2;
      r_s1    <= r_s0;
      r_s2    <= r_s1;
    end
  end

  // Receiver FSM with output handshake
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_perr_f   <= 1'b0;
      r_ferr_f   <= 1'b0;
      r_brk_f    <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_ovr      <= 1'b0;
      r_brk      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      r_brk <= 1'b0;

      // Consumer handshake outside DONE; DONE handles it together with loading
      if (r_valid && rx_ready && (r_state != ST_DONE)) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_fall) begin
            r_state <= ST_START;
            r_busy  <= 1'b1;
          end
        end

        ST_START: begin
          r_cnt <= w_cnt_nxt;
          if (w_mid) begin
            if (w_maj) begin
              // Line back high at mid start bit: treat as glitch
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state  <= ST_DATA;
              r_idx    <= '0;
              r_perr_f <= 1'b0;
              r_ferr_f <= 1'b0;
              r_brk_f  <= 1'b1;
            end
          end
        end

        ST_DATA: begin
          r_cnt <= w_cnt_nxt;
          if (w_mid) begin
            r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
            r_brk_f <= r_brk_f & ~w_maj;
            if (r_idx == IDX_LAST) begin
              r_state    <= HAS_PAR ? ST_PARITY : ST_STOP;
              r_stop_idx <= 1'b0;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end

        ST_PARITY: begin
          r_cnt <= w_cnt_nxt;
          if (w_mid) begin
            r_perr_f   <= w_par_bad;
            r_brk_f    <= r_brk_f & ~w_maj;
            r_state    <= ST_STOP;
            r_stop_idx <= 1'b0;
          end
        end

        ST_STOP: begin
          r_cnt <= w_cnt_nxt;
          if (w_mid) begin
            if (!w_maj) begin
              r_ferr_f <= 1'b1;
            end
            // Only the first stop bit takes part in break detection
            if (r_stop_idx == 1'b0) begin
              r_brk_f <= r_brk_f & ~w_maj;
            end
            if (r_stop_idx == STOP_LAST) begin
              r_state <= ST_DONE;
            end else begin
              r_stop_idx <= r_stop_idx + 1'b1;
            end
          end
        end

        ST_DONE: begin
          r_cnt <= '0;
          if (!r_valid || rx_ready) begin
            r_data  <= r_shift;
            r_perr  <= r_perr_f;
            r_ferr  <= r_ferr_f;
            r_valid <= 1'b1;
          end else begin
            r_ovr <= 1'b1;
          end
          if (r_brk_f) begin
            r_state <= ST_BRK_WAIT;
            r_brk   <= 1'b1;
          end else begin
            // Straight to IDLE so a start edge right after the stop bit is seen
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        ST_BRK_WAIT: begin
          // Need one full bit period of continuous high before re-arming
          if (!r_s0) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;
  assign break_det  = r_brk;
  assign busy       = r_busy;

endmodule
